// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family: limit-handling modes and one-shot FSM states.
package counter_pkg;

    // 2'b11 is reserved; the counter treats it exactly like MODE_WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/counter_updown_mod.sv
// Up/down counter with runtime modulus, clamped parallel load and wrap/saturate/one-shot limits.
// Priority per cycle is reset > load > en; carry and done are registered alongside count.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  mode_t        mode,
    input  logic [N-1:0] max_val,
    input  logic         load,
    input  logic [N-1:0] load_data,
    output logic [N-1:0] count,
    output logic         carry,
    output logic         done,
    output logic         at_limit
);

    localparam logic [N-1:0] RESET_COUNT = N'(RESET_VAL);

    logic [N-1:0] count_q, count_d;
    logic         carry_q, carry_d;
    state_t       state_q, state_d;

    logic outOfRange;
    logic atBoundary;
    logic wrapMode;

    assign outOfRange = (count_q > max_val);
    assign atBoundary = up ? (count_q == max_val) : (count_q == '0);
    assign wrapMode   = (mode == MODE_WRAP) || (mode == MODE_RSVD);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_COUNT;
            carry_q <= 1'b0;
            state_q <= RUN;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            state_q <= state_d;
        end
    end

    // A count above max_val (e.g. after the limit was lowered) is pulled back silently, no carry.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        state_d = state_q;
        if (load) begin
            count_d = (load_data > max_val) ? max_val : load_data;
            state_d = RUN;
        end else if (en && (state_q == RUN)) begin
            if (outOfRange) begin
                count_d = (up && wrapMode) ? '0 : max_val;
            end else if (atBoundary) begin
                case (mode)
                    MODE_SAT: begin
                        count_d = count_q;
                    end
                    MODE_ONESHOT: begin
                        count_d = count_q;
                        carry_d = 1'b1;
                        state_d = DONE;
                    end
                    default: begin
                        count_d = up ? '0 : max_val;
                        carry_d = 1'b1;
                    end
                endcase
            end else begin
                count_d = up ? (count_q + 1'b1) : (count_q - 1'b1);
            end
        end
    end

    always_comb begin
        count    = count_q;
        carry    = carry_q;
        done     = (state_q == DONE);
        at_limit = up ? (count_q == max_val) : (count_q == '0);
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench for counter_updown_mod at N=4, checked with immediate assertions.
module tb_counter_updown_mod;
    import counter_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    mode_t        mode;
    logic [N-1:0] max_val;
    logic         load;
    logic [N-1:0] load_data;
    logic [N-1:0] count;
    logic         carry;
    logic         done;
    logic         at_limit;

    int checks = 0;
    int errors = 0;

    counter_updown_mod #(.N(N), .RESET_VAL(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .mode      (mode),
        .max_val   (max_val),
        .load      (load),
        .load_data (load_data),
        .count     (count),
        .carry     (carry),
        .done      (done),
        .at_limit  (at_limit)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so outputs are sampled well away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        assert (actual === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int expCount, input int expCarry, input int expDone);
        checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
        checkOutput({tag, ".carry"}, 32'(carry), 32'(expCarry));
        checkOutput({tag, ".done"},  32'(done),  32'(expDone));
    endtask

    initial begin
        int expWrapUp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int expWrapDn [3]  = '{1, 0, 9};
        int expSat    [5]  = '{4, 5, 5, 5, 5};

        // Reset wins over simultaneous load and enable.
        reset = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1;
        mode = MODE_WRAP; max_val = 4'd9; load_data = 4'd5;
        applyStimulus();
        checkAll("reset_prio", 0, 0, 0);
        checkOutput("reset_prio.at_limit", 32'(at_limit), 32'd0);

        // Wrap up through max_val=9.
        reset = 1'b0; load = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            checkAll($sformatf("wrap_up[%0d]", i), expWrapUp[i], (expWrapUp[i] == 0) ? 1 : 0, 0);
        end

        // Wrap down from 2.
        up = 1'b0;
        #0 checkOutput("wrap_dn.at_limit_pre", 32'(at_limit), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkAll($sformatf("wrap_dn[%0d]", i), expWrapDn[i], (expWrapDn[i] == 9) ? 1 : 0, 0);
        end

        // Saturate at max_val=5 after loading 3.
        mode = MODE_SAT; max_val = 4'd5; up = 1'b1; en = 1'b0;
        load = 1'b1; load_data = 4'd3;
        applyStimulus();
        checkAll("sat_load", 3, 0, 0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkAll($sformatf("sat[%0d]", i), expSat[i], 0, 0);
            checkOutput($sformatf("sat[%0d].at_limit", i), 32'(at_limit), (expSat[i] == 5) ? 32'd1 : 32'd0);
        end

        // One-shot to max_val=3; the step taken at 3 raises carry and done.
        mode = MODE_ONESHOT; max_val = 4'd3; en = 1'b0;
        load = 1'b1; load_data = 4'd0;
        applyStimulus();
        checkAll("os_load0", 0, 0, 0);
        load = 1'b0; en = 1'b1;
        applyStimulus(); checkAll("os_1", 1, 0, 0);
        applyStimulus(); checkAll("os_2", 2, 0, 0);
        applyStimulus(); checkAll("os_3", 3, 0, 0);
        applyStimulus(); checkAll("os_hit", 3, 1, 1);
        applyStimulus(); checkAll("os_hold", 3, 0, 1);
        mode = MODE_WRAP;
        applyStimulus(); checkAll("os_mode_chg", 3, 0, 1);
        load = 1'b1; load_data = 4'd1;
        applyStimulus(); checkAll("os_reload", 1, 0, 0);

        // Load clamp, then out-of-range recovery in SAT/down and WRAP/up.
        mode = MODE_SAT; max_val = 4'd6; load_data = 4'd12; load = 1'b1; en = 1'b0;
        applyStimulus(); checkAll("clamp", 6, 0, 0);
        load = 1'b0; max_val = 4'd2; up = 1'b0; en = 1'b1;
        applyStimulus(); checkAll("oor_sat_dn", 2, 0, 0);
        max_val = 4'd6; load = 1'b1; en = 1'b0;
        applyStimulus(); checkAll("clamp2", 6, 0, 0);
        load = 1'b0; max_val = 4'd2; mode = MODE_WRAP; up = 1'b1; en = 1'b1;
        applyStimulus(); checkAll("oor_wrap_up", 0, 0, 0);

        // Degenerate modulus: every step is a wrap boundary.
        max_val = 4'd0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkAll($sformatf("max0[%0d]", i), 0, 1, 0);
            checkOutput($sformatf("max0[%0d].at_limit", i), 32'(at_limit), 32'd1);
        end

        // Reserved mode encoding behaves as wrap.
        mode = MODE_RSVD; max_val = 4'd2; load = 1'b1; load_data = 4'd2; en = 1'b0;
        applyStimulus(); checkAll("rsvd_load", 2, 0, 0);
        load = 1'b0; en = 1'b1;
        applyStimulus(); checkAll("rsvd_wrap", 0, 1, 0);

        // Reset out of DONE overrides load and enable.
        mode = MODE_ONESHOT; max_val = 4'd1; load = 1'b1; load_data = 4'd1; en = 1'b0;
        applyStimulus(); checkAll("rst_pre_load", 1, 0, 0);
        load = 1'b0; en = 1'b1;
        applyStimulus(); checkAll("rst_pre_done", 1, 1, 1);
        reset = 1'b1; load = 1'b1; load_data = 4'd1;
        applyStimulus(); checkAll("rst_from_done", 0, 0, 0);
        reset = 1'b0; load = 1'b0;
        applyStimulus(); checkAll("rst_after", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
